// File: rtl/axi_led_ctrl_if.sv
// AXI-Lite channel bundle used between the system interconnect and the LED
// peripheral. Single-beat only; wlast/rlast are carried for bus compatibility.
interface axi_led_ctrl_if;
  // write address channel
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  // write data channel
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        wlast;
  // write response channel
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  // read address channel
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  // read data channel
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rlast;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wlast, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rlast
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wlast, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/axi_led_ctrl.sv
// AXI-Lite LED peripheral: static LED value, blink mask, blink period and a
// read-only status word, plus a free-running blink prescaler that drives the
// registered LED pins. Only the low address byte is decoded; the interconnect
// has already stripped the window base.
module axi_led_ctrl #(
  parameter int          LED_NUM   = 8,
  parameter logic [31:0] BLINK_RST = 32'd50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  axi_led_ctrl_if.slave      axi,
  output logic [LED_NUM-1:0] led
);

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // word indices of the register map (byte offset >> 2)
  localparam logic [5:0]  IDX_LED    = 6'd0;
  localparam logic [5:0]  IDX_MASK   = 6'd1;
  localparam logic [5:0]  IDX_PERIOD = 6'd2;
  localparam logic [5:0]  IDX_STATUS = 6'd3;
  localparam logic [15:0] STATUS_TAG = 16'hAD1E;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Offsets 0x00..0x0F are backed by a register; everything else is a hole.
  function automatic logic is_mapped(input logic [7:0] off);
    return (off[7:4] == 4'h0);
  endfunction

  // ---------------------------------------------------------------------
  // register file and blink state
  // ---------------------------------------------------------------------
  logic [LED_NUM-1:0] led_out_r;
  logic [LED_NUM-1:0] mask_r;
  logic [31:0]        period_r;
  logic [31:0]        cnt_r;
  logic [31:0]        cnt_s;
  logic               phase_r;
  logic               phase_s;
  logic               wrap_s;
  logic               period_wr_s;
  logic [LED_NUM-1:0] led_r;
  logic [LED_NUM-1:0] led_s;

  // ---------------------------------------------------------------------
  // write channel state
  // ---------------------------------------------------------------------
  w_state_t    w_state_r;
  w_state_t    w_state_s;
  logic        aw_held_r;
  logic        aw_held_s;
  logic        w_held_r;
  logic        w_held_s;
  logic [7:0]  aw_addr_r;
  logic [7:0]  aw_addr_s;
  logic [31:0] w_data_r;
  logic [31:0] w_data_s;
  logic        awready_r;
  logic        awready_s;
  logic        wready_r;
  logic        wready_s;
  logic        bvalid_r;
  logic        bvalid_s;
  logic [1:0]  bresp_r;
  logic [1:0]  bresp_s;
  logic        aw_hs_s;
  logic        w_hs_s;
  logic        commit_s;
  logic [7:0]  commit_addr_s;
  logic [31:0] commit_data_s;

  // ---------------------------------------------------------------------
  // read channel state
  // ---------------------------------------------------------------------
  r_state_t    r_state_r;
  r_state_t    r_state_s;
  logic        arready_r;
  logic        arready_s;
  logic        rvalid_r;
  logic        rvalid_s;
  logic        rlast_r;
  logic        rlast_s;
  logic [31:0] rdata_r;
  logic [31:0] rdata_s;
  logic [31:0] rd_word_s;
  logic        ar_hs_s;

  // Address bits outside the decoded window and wlast carry no information
  // for this block; fold them here so they are visibly consumed.
  logic unused_bits_s;
  assign unused_bits_s = ^{axi.awaddr[31:8], axi.awaddr[1:0],
                           axi.araddr[31:8], axi.araddr[1:0], axi.wlast};

  assign aw_hs_s = axi.awvalid & awready_r;
  assign w_hs_s  = axi.wvalid  & wready_r;
  assign ar_hs_s = axi.arvalid & arready_r;

  assign axi.awready = awready_r;
  assign axi.wready  = wready_r;
  assign axi.bvalid  = bvalid_r;
  assign axi.bresp   = bresp_r;
  assign axi.arready = arready_r;
  assign axi.rvalid  = rvalid_r;
  assign axi.rlast   = rlast_r;
  assign axi.rdata   = rdata_r;
  assign led         = led_r;

  // Write FSM next state: capture AW and W independently, commit once both are in.
  always_comb begin
    w_state_s = w_state_r;
    aw_held_s = aw_held_r;
    w_held_s  = w_held_r;
    aw_addr_s = aw_addr_r;
    w_data_s  = w_data_r;
    bvalid_s  = bvalid_r;
    bresp_s   = bresp_r;
    commit_s  = 1'b0;
    // a channel handshaking this very edge takes precedence over the held copy
    commit_addr_s = aw_hs_s ? axi.awaddr[7:0] : aw_addr_r;
    commit_data_s = w_hs_s  ? axi.wdata       : w_data_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s) begin
          aw_addr_s = axi.awaddr[7:0];
        end else begin
          aw_addr_s = aw_addr_r;
        end
        if (w_hs_s) begin
          w_data_s = axi.wdata;
        end else begin
          w_data_s = w_data_r;
        end
        if ((aw_hs_s | aw_held_r) & (w_hs_s | w_held_r)) begin
          commit_s  = 1'b1;
          bvalid_s  = 1'b1;
          bresp_s   = is_mapped(commit_addr_s) ? RESP_OKAY : RESP_SLVERR;
          aw_held_s = 1'b0;
          w_held_s  = 1'b0;
          w_state_s = W_RESP;
        end else begin
          aw_held_s = aw_held_r | aw_hs_s;
          w_held_s  = w_held_r  | w_hs_s;
          w_state_s = W_IDLE;
        end
      end
      W_RESP: begin
        if (axi.bready) begin
          bvalid_s  = 1'b0;
          w_state_s = W_IDLE;
        end else begin
          bvalid_s  = 1'b1;
          w_state_s = W_RESP;
        end
      end
      default: begin
        w_state_s = W_IDLE;
        aw_held_s = 1'b0;
        w_held_s  = 1'b0;
        bvalid_s  = 1'b0;
      end
    endcase
    awready_s = (w_state_s == W_IDLE) & ~aw_held_s;
    wready_s  = (w_state_s == W_IDLE) & ~w_held_s;
  end

  // Write FSM state and registered write-channel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r <= W_IDLE;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_addr_r <= 8'd0;
      w_data_r  <= 32'd0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      w_state_r <= w_state_s;
      aw_held_r <= aw_held_s;
      w_held_r  <= w_held_s;
      aw_addr_r <= aw_addr_s;
      w_data_r  <= w_data_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bvalid_r  <= bvalid_s;
      bresp_r   <= bresp_s;
    end
  end

  // Register file update on a committed write; STATUS and holes are not writable.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_out_r <= '0;
      mask_r    <= '0;
      period_r  <= BLINK_RST;
    end else if (commit_s) begin
      case (commit_addr_s[7:2])
        IDX_LED:    led_out_r <= commit_data_s[LED_NUM-1:0];
        IDX_MASK:   mask_r    <= commit_data_s[LED_NUM-1:0];
        IDX_PERIOD: period_r  <= commit_data_s;
        default:    period_r  <= period_r;
      endcase
    end else begin
      period_r <= period_r;
    end
  end

  // Read mux over the current register values (pre-commit on a shared edge).
  always_comb begin
    rd_word_s = 32'd0;
    case (axi.araddr[7:2])
      IDX_LED:    rd_word_s[LED_NUM-1:0] = led_out_r;
      IDX_MASK:   rd_word_s[LED_NUM-1:0] = mask_r;
      IDX_PERIOD: rd_word_s = period_r;
      IDX_STATUS: rd_word_s = {STATUS_TAG, 8'(LED_NUM), 7'd0, phase_r};
      default:    rd_word_s = 32'd0;
    endcase
  end

  // Read FSM next state: one outstanding read, data held until accepted.
  always_comb begin
    r_state_s = r_state_r;
    rvalid_s  = rvalid_r;
    rlast_s   = rlast_r;
    rdata_s   = rdata_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          rdata_s   = rd_word_s;
          rvalid_s  = 1'b1;
          rlast_s   = 1'b1;
          r_state_s = R_DATA;
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (axi.rready) begin
          rvalid_s  = 1'b0;
          rlast_s   = 1'b0;
          r_state_s = R_IDLE;
        end else begin
          r_state_s = R_DATA;
        end
      end
      default: begin
        r_state_s = R_IDLE;
        rvalid_s  = 1'b0;
        rlast_s   = 1'b0;
      end
    endcase
    arready_s = (r_state_s == R_IDLE);
  end

  // Read FSM state and registered read-channel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rdata_r   <= 32'd0;
    end else begin
      r_state_r <= r_state_s;
      arready_r <= arready_s;
      rvalid_r  <= rvalid_s;
      rlast_r   <= rlast_s;
      rdata_r   <= rdata_s;
    end
  end

  // Blink prescaler next state; a period write restarts the count but the
  // wrap decision for this edge still uses the old period.
  always_comb begin
    period_wr_s = commit_s & (commit_addr_s[7:2] == IDX_PERIOD);
    wrap_s      = (period_r != 32'd0) & (cnt_r == (period_r - 32'd1));
    if (period_wr_s) begin
      cnt_s = 32'd0;
    end else if (period_r == 32'd0) begin
      cnt_s = 32'd0;
    end else if (wrap_s) begin
      cnt_s = 32'd0;
    end else begin
      cnt_s = cnt_r + 32'd1;
    end
    if (wrap_s) begin
      phase_s = ~phase_r;
    end else begin
      phase_s = phase_r;
    end
    led_s = led_out_r ^ (mask_r & {LED_NUM{phase_r}});
  end

  // Blink prescaler, phase and LED pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 32'd0;
      phase_r <= 1'b0;
      led_r   <= '0;
    end else begin
      cnt_r   <= cnt_s;
      phase_r <= phase_s;
      led_r   <= led_s;
    end
  end

endmodule
